// File: rtl/spi_write_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_ctrl_pkg
//   Shared types and constants for the SPI flash write controller.
//   - state_e       : controller FSM states (also exported for debug)
//   - BITS_PER_BYTE : bits shifted per SPI byte
//   - CMD_*         : common SPI flash command opcodes
// ---------------------------------------------------------------------------
package spi_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CS_SETUP,
        CMD,
        ADDR,
        FETCH,
        WAIT_DATA,
        DATA,
        CS_HOLD,
        DONE
    } state_e;

    localparam int BITS_PER_BYTE = 8;

    localparam logic [7:0] CMD_PAGE_PROG = 8'h02;
    localparam logic [7:0] CMD_WREN      = 8'h06;

endpackage

// File: rtl/spi_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_write_ctrl_if
//   Bundles the host request, FIFO read port and SPI pins of the write
//   controller.
//   Host side : start, cmd, addr, len (in); busy, done (out)
//   FIFO side : fifo_dout, fifo_empty (in); fifo_rd_en (out)
//   SPI pins  : spi_sclk, spi_cs_n, spi_mosi (out)
//
//   Handshake: start is a request that is accepted only while the controller
//   is idle (busy=0 and done=0); cmd/addr/len are captured in that same cycle
//   and may change freely afterwards. busy is high from the cycle after
//   acceptance until the transaction ends; done pulses for exactly one cycle
//   with busy=0. A start asserted in the cycle after done is accepted.
//   fifo_rd_en pops one byte; fifo_dout holds it in the following cycle.
//
//   Modports: slave = controller view, master = host/FIFO/bench view.
// ---------------------------------------------------------------------------
interface spi_write_ctrl_if #(
    parameter int ADDR_BYTES = 3,
    parameter int LEN_W      = 6
) ();

    logic                    start;
    logic [7:0]              cmd;
    logic [8*ADDR_BYTES-1:0] addr;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic                    done;
    logic                    fifo_rd_en;
    logic [7:0]              fifo_dout;
    logic                    fifo_empty;
    logic                    spi_sclk;
    logic                    spi_cs_n;
    logic                    spi_mosi;

    modport slave (
        input  start, cmd, addr, len, fifo_dout, fifo_empty,
        output busy, done, fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi
    );

    modport master (
        output start, cmd, addr, len, fifo_dout, fifo_empty,
        input  busy, done, fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi
    );

endinterface

// File: rtl/spi_byte_shifter.sv
// ---------------------------------------------------------------------------
// spi_byte_shifter
//   SCLK divider plus 8-bit MSB-first shifter, SPI mode 0.
//   Each bit: SCLK low for CLK_DIV cycles (MOSI = shreg[7]), then high for
//   CLK_DIV cycles; the register shifts left when SCLK falls. The last bit
//   does not shift so MOSI holds its value between bytes.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     load_i       : start a new byte from din_i (wins over byte_done_o,
//                    so bytes can run back to back)
//     din_i[7:0]   : byte to send
//     busy_o       : a byte is in flight
//     byte_done_o  : last cycle of the final high phase
//     sclk_o       : serial clock
//     mosi_o       : serial data
// ---------------------------------------------------------------------------
module spi_byte_shifter
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] din_i,
    output logic       busy_o,
    output logic       byte_done_o,
    output logic       sclk_o,
    output logic       mosi_o
);

    localparam int                DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]        BIT_LAST = 3'(BITS_PER_BYTE - 1);

    logic [7:0]       shreg_q, shreg_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [2:0]       bit_q,   bit_d;
    logic             phase_q, phase_d;   // 0 = SCLK low, 1 = SCLK high
    logic             busy_q,  busy_d;
    logic             div_end;

    assign div_end     = busy_q && (div_q == DIV_LAST);
    assign byte_done_o = div_end && phase_q && (bit_q == BIT_LAST);
    assign busy_o      = busy_q;
    assign sclk_o      = busy_q & phase_q;
    assign mosi_o      = shreg_q[7];

    always_comb begin
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        if (load_i) begin
            shreg_d = din_i;
            div_d   = '0;
            bit_d   = '0;
            phase_d = 1'b0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (div_end) begin
                div_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        busy_d = 1'b0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/spi_write_ctrl.sv
// ---------------------------------------------------------------------------
// spi_write_ctrl
//   Sequences one SPI flash write: command byte, ADDR_BYTES address bytes
//   (MSB byte first), then len payload bytes popped from a FIFO whose read
//   data appears the cycle after fifo_rd_en. Owns CS, SCLK and the FIFO
//   read strobe. ADDR_BYTES must be at least 1, CLK_DIV at least 1.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset (aborts immediately)
//     bus      : spi_write_ctrl_if.slave (host request, FIFO port, SPI pins)
//     state_o  : current FSM state, for debug
// ---------------------------------------------------------------------------
module spi_write_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_BYTES = 3,
    parameter int LEN_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_write_ctrl_if.slave      bus,
    output state_e               state_o
);

    localparam int                AW       = 8 * ADDR_BYTES;
    localparam int                BC_W     = $clog2(ADDR_BYTES + 1);
    localparam int                DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_e           state_q, state_d;
    logic [7:0]       cmd_q,   cmd_d;
    logic [AW-1:0]    addr_q,  addr_d;    // shifted left as bytes are sent
    logic [LEN_W-1:0] len_q,   len_d;
    logic [LEN_W-1:0] pay_q,   pay_d;     // payload bytes still to send
    logic [BC_W-1:0]  byte_q,  byte_d;    // address bytes already loaded
    logic [DIV_W-1:0] wait_q,  wait_d;    // CS setup/hold timer

    logic       sh_load;
    logic [7:0] sh_din;
    logic       sh_busy;
    logic       sh_byte_done;
    logic       sh_sclk;
    logic       sh_mosi;
    logic       rd_en;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (sh_load),
        .din_i       (sh_din),
        .busy_o      (sh_busy),
        .byte_done_o (sh_byte_done),
        .sclk_o      (sh_sclk),
        .mosi_o      (sh_mosi)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        len_d   = len_q;
        pay_d   = pay_q;
        byte_d  = byte_q;
        wait_d  = wait_q;
        sh_load = 1'b0;
        sh_din  = cmd_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cmd_d   = bus.cmd;
                    addr_d  = bus.addr;
                    len_d   = bus.len;
                    pay_d   = '0;
                    byte_d  = '0;
                    wait_d  = '0;
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (wait_q == DIV_LAST) begin
                    wait_d  = '0;
                    sh_load = 1'b1;
                    sh_din  = cmd_q;
                    state_d = CMD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CMD: begin
                // Next byte is loaded in the byte_done cycle: no SCLK gap.
                if (sh_byte_done) begin
                    sh_load = 1'b1;
                    sh_din  = addr_q[AW-1 -: 8];
                    addr_d  = addr_q << 8;
                    byte_d  = BC_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (sh_byte_done) begin
                    if (byte_q == BC_W'(ADDR_BYTES)) begin
                        byte_d  = '0;
                        pay_d   = len_q;
                        state_d = (len_q == '0) ? CS_HOLD : FETCH;
                    end else begin
                        sh_load = 1'b1;
                        sh_din  = addr_q[AW-1 -: 8];
                        addr_d  = addr_q << 8;
                        byte_d  = byte_q + 1'b1;
                    end
                end
            end
            FETCH: begin
                // Stall here with SCLK low while the FIFO is empty.
                if (!bus.fifo_empty && !sh_busy) begin
                    rd_en   = 1'b1;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                sh_load = 1'b1;
                sh_din  = bus.fifo_dout;
                state_d = DATA;
            end
            DATA: begin
                if (sh_byte_done) begin
                    pay_d   = pay_q - 1'b1;
                    state_d = (pay_q == LEN_W'(1)) ? CS_HOLD : FETCH;
                end
            end
            CS_HOLD: begin
                if (wait_q == DIV_LAST) begin
                    wait_d  = '0;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            pay_q   <= '0;
            byte_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            pay_q   <= pay_d;
            byte_q  <= byte_d;
            wait_q  <= wait_d;
        end
    end

    // Control outputs decode straight from the state register so an
    // asynchronous reset releases CS and busy in the same cycle.
    assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
    assign bus.done       = (state_q == DONE);
    assign bus.spi_cs_n   = (state_q == IDLE) || (state_q == DONE);
    assign bus.fifo_rd_en = rd_en;
    assign bus.spi_sclk   = sh_sclk;
    assign bus.spi_mosi   = sh_mosi;
    assign state_o        = state_q;

endmodule

// File: doc/spi_write_ctrl.md
Name: spi_write_ctrl

Overview:
Sequences one SPI flash write transaction: command byte, ADDR_BYTES address bytes, then `len` payload bytes drained from the byte FIFO. The FIFO has a registered read port: data is valid the cycle after `fifo_rd_en`.
The block sits between the host-side write FIFO and the SPI pins. It owns chip-select, SCLK generation, and the FIFO read strobe.
It runs SPI mode 0, MSB first: SCLK idles low, MOSI changes while SCLK is low, and the slave samples on the rising edge.

Parameters:
- CLK_DIV, default 2: clk cycles per SCLK half-period. Must be ≥1.
- ADDR_BYTES, default 3: number of address bytes sent after the command.
- LEN_W, default 6: width of `len`. Covers a 53-byte FIFO.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: transaction request. Sampled only in IDLE.
- cmd, in, 8: command byte, captured on start.
- addr, in, 8*ADDR_BYTES: address, captured on start. Sent MSB byte first.
- len, in, LEN_W: payload byte count, captured on start. 0 is legal.
- busy, out, 1: high from the cycle after start is accepted until done.
- done, out, 1: one-cycle pulse when the transaction completes.
- fifo_rd_en, out, 1: FIFO read strobe. One cycle per payload byte.
- fifo_dout, in, 8: FIFO read data. Valid the cycle after fifo_rd_en.
- fifo_empty, in, 1: FIFO empty flag.
- spi_sclk, out, 1: serial clock.
- spi_cs_n, out, 1: chip select, active low.
- spi_mosi, out, 1: serial data out.

Behaviour:
- Reset values: busy=0, done=0, fifo_rd_en=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0, state=IDLE, all counters 0.
- Reset mid-transaction aborts immediately (asynchronous). CS deasserts with no trailing SCLK edge and no FIFO read.
- States: IDLE → CS_SETUP → CMD → ADDR → FETCH → WAIT_DATA → DATA → (FETCH | CS_HOLD) → DONE → IDLE.
- IDLE: when start=1, capture cmd/addr/len, and go to CS_SETUP next cycle with cs_n=0 and busy=1. While not in IDLE, start is ignored.
- CS_SETUP: hold for CLK_DIV cycles with sclk=0, then load cmd into the shift register.
- Bit timing, per bit:
  - mosi is driven with shreg[7] at the start of the low phase.
  - sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - shreg shifts left at the falling edge.
  - 8 bits make one byte, so one byte takes 16*CLK_DIV cycles.
- CMD → ADDR: no gap. ADDR sends ADDR_BYTES bytes back to back.
- After ADDR: if len==0 go to CS_HOLD, else go to FETCH. The payload counter is loaded with len.
- FETCH:
  - sclk=0, cs_n stays 0.
  - If fifo_empty=1, stall indefinitely with fifo_rd_en=0 and mosi held.
  - Otherwise assert fifo_rd_en for exactly 1 cycle and go to WAIT_DATA.
- WAIT_DATA: 1 cycle. Latch fifo_dout into shreg, then go to DATA. Each payload byte therefore has a minimum 2-cycle SCLK-low gap in front of it.
- DATA: shift 8 bits, then decrement the counter. If it reaches 0 go to CS_HOLD, else go to FETCH.
- CS_HOLD: CLK_DIV cycles with sclk=0 and cs_n=0.
- DONE: a single cycle with cs_n=1, done=1, busy=0, then go to IDLE. A start in the cycle after done is accepted.
- Exactly len fifo_rd_en pulses are issued per transaction. No read is ever issued while fifo_empty=1.
- No SCLK rising edge occurs while cs_n=1.
- Counters: use a bit counter (3 bits), a byte counter of width clog2(ADDR_BYTES+1), a payload counter of width LEN_W, and a divider of width clog2(CLK_DIV+1). None may wrap silently; every terminal count must transition state.

Decomposition:
- Package spi_ctrl_pkg holds:
  - the state enum (IDLE, CS_SETUP, CMD, ADDR, FETCH, WAIT_DATA, DATA, CS_HOLD, DONE);
  - the constant BITS_PER_BYTE=8;
  - the common command constants CMD_PAGE_PROG=8'h02 and CMD_WREN=8'h06.
- One sub-module, spi_byte_shifter: CLK_DIV divider plus 8-bit MSB-first shifter.
  - Interface: load, din[7:0], busy, byte_done, sclk, mosi.
  - The FSM in spi_write_ctrl drives load and consumes byte_done.

Test Plan:
- Single byte: CLK_DIV=2, cmd=8'h02, addr=24'h012345, len=1, FIFO holds 8'hA5.
  - Expect cs_n low for exactly 166 cycles (2+32+96+2+32+2) and 40 SCLK rising edges.
  - Expect captured MOSI = 02 01 23 45 A5, one fifo_rd_en pulse, done one cycle after cs_n rises.
- Zero length: len=0.
  - Expect 32 SCLK rises and no fifo_rd_en.
  - Expect cs_n low for 132 cycles, and done asserted.
- Full drain: len=53 with FIFO preloaded 0..52.
  - Expect 53 rd_en pulses and payload bytes received in order 0..52.
  - Expect fifo_empty=1 at done.
- Underrun stall: len=2, second byte written 10 cycles after the first byte completes.
  - Expect sclk low and cs_n low during the stall, rd_en only after empty falls.
  - Expect correct bytes received, and the transaction 10 cycles longer than baseline.
- Reset mid-address: assert rst during ADDR.
  - Expect cs_n=1, sclk=0, busy=0 in the same cycle (asynchronous).
  - Expect no further rd_en, and a new start after release to complete normally.
- Start while busy: pulse start during DATA with different cmd/addr.
  - Expect it ignored and the original transaction unaltered.
  - Expect back-to-back start in the cycle after done to be accepted.
